seg7_capture: RTL



---
 rtl/seg7_pkg.sv | 30 +++
 rtl/seg7_capture_if.sv | 23 ++
 rtl/seg7_pattern_dec.sv | 35 +++
 rtl/seg7_capture.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and the active-low 7-segment code table for seg7_capture.
// Patterns are written bit6=g .. bit0=a; a 0 bit lights the segment.
package seg7_pkg;

    typedef logic [6:0] seg_t;

    typedef enum logic {
        S_TRACK,
        S_OFFER
    } cap_state_t;

    localparam seg_t SEG_0     = 7'b1000000;
    localparam seg_t SEG_1     = 7'b1111001;
    localparam seg_t SEG_2     = 7'b0100100;
    localparam seg_t SEG_3     = 7'b0110000;
    localparam seg_t SEG_4     = 7'b0011001;
    localparam seg_t SEG_5     = 7'b0010010;
    localparam seg_t SEG_6     = 7'b0000010;
    localparam seg_t SEG_7     = 7'b1111000;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0011000;
    localparam seg_t SEG_A     = 7'b0001000;
    localparam seg_t SEG_B     = 7'b0000011;
    localparam seg_t SEG_C     = 7'b1000110;
    localparam seg_t SEG_D     = 7'b0100001;
    localparam seg_t SEG_E     = 7'b0000110;
    localparam seg_t SEG_F     = 7'b0001110;
    localparam seg_t SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_capture_if.sv
// Downstream offer bundle: decoded pair, error flags, overrun, handshake.
// master = seg7_capture (drives o_*), slave = consumer (drives i_ready).
interface seg7_capture_if;
    logic       i_ready;
    logic       o_valid;
    logic [3:0] o_tens;
    logic [3:0] o_ones;
    logic       o_errL;
    logic       o_errR;
    logic       o_overrun;

    modport master (
        input  i_ready,
        output o_valid, o_tens, o_ones,
        output o_errL, o_errR, o_overrun
    );

    modport slave (
        output i_ready,
        input  o_valid, o_tens, o_ones,
        input  o_errL, o_errR, o_overrun
    );
endinterface

// File: rtl/seg7_pattern_dec.sv
// Combinational 7-segment pattern to hex decoder.
// Ports: i_seg pattern in; o_val hex value, o_err set for unknown codes.
module seg7_pattern_dec
    import seg7_pkg::*;
(
    input  seg_t       i_seg,
    output logic [3:0] o_val,
    output logic       o_err
);

    always_comb begin
        o_val = 4'h0;
        o_err = 1'b0;
        unique case (i_seg)
            SEG_0:   o_val = 4'h0;
            SEG_1:   o_val = 4'h1;
            SEG_2:   o_val = 4'h2;
            SEG_3:   o_val = 4'h3;
            SEG_4:   o_val = 4'h4;
            SEG_5:   o_val = 4'h5;
            SEG_6:   o_val = 4'h6;
            SEG_7:   o_val = 4'h7;
            SEG_8:   o_val = 4'h8;
            SEG_9:   o_val = 4'h9;
            SEG_A:   o_val = 4'hA;
            SEG_B:   o_val = 4'hB;
            SEG_C:   o_val = 4'hC;
            SEG_D:   o_val = 4'hD;
            SEG_E:   o_val = 4'hE;
            SEG_F:   o_val = 4'hF;
            default: o_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_capture.sv
// Samples a tens/ones segment pair, waits for stability, offers decoded hex.
// Ports: i_clk, i_rst (sync, high), i_segL/i_segR patterns, out_if offer.
module seg7_capture
    import seg7_pkg::*;
#(
    parameter  int STABLE_CYCLES = 4,
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1)
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  seg_t           i_segL,
    input  seg_t           i_segR,
    seg7_capture_if.master out_if
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    cap_state_t       state_q, state_d;
    logic [13:0]      pair_q, pair_d;
    logic [13:0]      last_q, last_d;
    logic [13:0]      off_q, off_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             first_q, first_d;
    logic             valid_q, valid_d;
    logic [3:0]       tens_q, tens_d;
    logic [3:0]       ones_q, ones_d;
    logic             errl_q, errl_d;
    logic             errr_q, errr_d;
    logic             ovr_q, ovr_d;

    logic [3:0] dec_l, dec_r;
    logic       err_l, err_r;
    logic       stable;

    seg7_pattern_dec u_dec_l (
        .i_seg (pair_q[13:7]),
        .o_val (dec_l),
        .o_err (err_l)
    );

    seg7_pattern_dec u_dec_r (
        .i_seg (pair_q[6:0]),
        .o_val (dec_r),
        .o_err (err_r)
    );

    // cnt_q = number of cycles pair_q has held its current value, so the
    // incoming sample is compared with the pair it is about to replace.
    always_comb begin
        pair_d = {i_segL, i_segR};
        if (pair_d == pair_q) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end else begin
            cnt_d = CNT_W'(1);
        end
    end

    assign stable = (cnt_q == CNT_MAX);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        off_d   = off_q;
        first_d = first_q;
        valid_d = valid_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        errl_d  = errl_q;
        errr_d  = errr_q;
        ovr_d   = 1'b0;
        unique case (state_q)
            S_TRACK: begin
                if (stable && (first_q || pair_q != last_q)) begin
                    off_d   = pair_q;
                    tens_d  = dec_l;
                    ones_d  = dec_r;
                    errl_d  = err_l;
                    errr_d  = err_r;
                    valid_d = 1'b1;
                    state_d = S_OFFER;
                end
            end
            S_OFFER: begin
                // A completing handshake wins over a newer stable pair;
                // that pair is picked up from S_TRACK next cycle.
                if (out_if.i_ready) begin
                    last_d  = off_q;
                    first_d = 1'b0;
                    valid_d = 1'b0;
                    state_d = S_TRACK;
                end else if (stable && pair_q != off_q) begin
                    off_d  = pair_q;
                    tens_d = dec_l;
                    ones_d = dec_r;
                    errl_d = err_l;
                    errr_d = err_r;
                    ovr_d  = 1'b1;
                end
            end
            default: state_d = S_TRACK;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_TRACK;
            pair_q  <= {SEG_BLANK, SEG_BLANK};
            last_q  <= '1;
            off_q   <= '1;
            cnt_q   <= '0;
            first_q <= 1'b1;
            valid_q <= 1'b0;
            tens_q  <= 4'h0;
            ones_q  <= 4'h0;
            errl_q  <= 1'b0;
            errr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pair_q  <= pair_d;
            last_q  <= last_d;
            off_q   <= off_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            valid_q <= valid_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            errl_q  <= errl_d;
            errr_q  <= errr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign out_if.o_valid   = valid_q;
    assign out_if.o_tens    = tens_q;
    assign out_if.o_ones    = ones_q;
    assign out_if.o_errL    = errl_q;
    assign out_if.o_errR    = errr_q;
    assign out_if.o_overrun = ovr_q;

endmodule
